// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM tile scheduler.
//   NUM_BIT  : signed Q1.7 element width
//   DIM      : result vector length
//   state_t  : scheduler FSM states
//   sat_add  : saturating signed add of two elements
package mvm_pkg;

    localparam int unsigned NUM_BIT = 8;
    localparam int unsigned DIM     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BUSY,
        ST_ACCUM,
        ST_OUTPUT
    } state_t;

    typedef logic signed [NUM_BIT-1:0] elem_t;

    // Sum at NUM_BIT+1 bits; if the top two bits disagree the result left the
    // representable range and is pinned to the limit on the side of the sign.
    function automatic elem_t sat_add(input elem_t a, input elem_t b);
        logic signed [NUM_BIT:0] s;
        s = (NUM_BIT+1)'(a) + (NUM_BIT+1)'(b);
        if (s[NUM_BIT] != s[NUM_BIT-1]) begin
            return s[NUM_BIT] ? {1'b1, {(NUM_BIT-1){1'b0}}}
                              : {1'b0, {(NUM_BIT-1){1'b1}}};
        end
        return s[NUM_BIT-1:0];
    endfunction

endpackage

// File: rtl/mvm_sched_if.sv
// Job / fetch / MVM / result signal bundle of the MVM tile scheduler.
//   master : scheduler side (drives o_*, receives i_*)
//   slave  : environment side (job source, operand fetcher, MVM datapath,
//            result sink)
interface mvm_sched_if #(
    parameter int unsigned NUM_BIT   = mvm_pkg::NUM_BIT,
    parameter int unsigned DIM       = mvm_pkg::DIM,
    parameter int unsigned MAX_TILES = 16
);

    localparam int unsigned TILE_W = $clog2(MAX_TILES + 1);
    localparam int unsigned IDX_W  = $clog2(MAX_TILES);

    logic                          i_job_valid;
    logic [TILE_W-1:0]             i_job_tiles;
    logic                          o_job_ready;
    logic                          o_fetch_req;
    logic [IDX_W-1:0]              o_fetch_tile;
    logic                          i_fetch_ack;
    logic                          o_mvm_start;
    logic                          i_mvm_isAcc;
    logic [DIM-1:0][NUM_BIT-1:0]   i_mvm_y;
    logic [DIM-1:0][NUM_BIT-1:0]   o_y_vector;
    logic                          o_out_valid;
    logic                          i_out_ready;
    logic                          o_busy;
    logic                          o_err;

    modport master (
        input  i_job_valid, i_job_tiles, i_fetch_ack, i_mvm_isAcc, i_mvm_y,
               i_out_ready,
        output o_job_ready, o_fetch_req, o_fetch_tile, o_mvm_start,
               o_y_vector, o_out_valid, o_busy, o_err
    );

    modport slave (
        output i_job_valid, i_job_tiles, i_fetch_ack, i_mvm_isAcc, i_mvm_y,
               i_out_ready,
        input  o_job_ready, o_fetch_req, o_fetch_tile, o_mvm_start,
               o_y_vector, o_out_valid, o_busy, o_err
    );

endinterface

// File: rtl/mvm_acc_bank.sv
// Bank of DIM saturating accumulators.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero all accumulators (takes priority over en)
//   en       : acc[i] <= sat(acc[i] + addend[i])
//   addend   : vector added when en is high
//   acc      : accumulator contents
module mvm_acc_bank #(
    parameter int unsigned NUM_BIT = mvm_pkg::NUM_BIT,
    parameter int unsigned DIM     = mvm_pkg::DIM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic [DIM-1:0][NUM_BIT-1:0] addend,
    output logic [DIM-1:0][NUM_BIT-1:0] acc
);

    import mvm_pkg::*;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < DIM; i++) begin
                acc[i] <= sat_add(acc[i], addend[i]);
            end
        end
    end

endmodule

// File: rtl/mvm_sched.sv
// MVM tile scheduler: accepts a job of N tiles, fetches each tile's operands,
// starts the MVM datapath, waits for the accumulating flag to fall, adds the
// MVM result into a saturating accumulator bank and finally presents the
// accumulated vector on a valid/ready handshake.
//   i_clk_mvmSched : clock, rising edge
//   i_rst_mvmSched : synchronous active-high reset
//   bus            : job, fetch, MVM and result signals (mvm_sched_if.master)
// A job that stays in BUSY for TIMEOUT cycles is dropped with sticky o_err.
module mvm_sched #(
    parameter int unsigned NUM_BIT   = mvm_pkg::NUM_BIT,
    parameter int unsigned DIM       = mvm_pkg::DIM,
    parameter int unsigned MAX_TILES = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          i_clk_mvmSched,
    input  logic          i_rst_mvmSched,
    mvm_sched_if.master   bus
);

    import mvm_pkg::*;

    localparam int unsigned TILE_W = $clog2(MAX_TILES + 1);
    localparam int unsigned IDX_W  = $clog2(MAX_TILES);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    state_t                       state;
    logic [TILE_W-1:0]            tiles;
    logic [IDX_W-1:0]             idx;
    logic [CNT_W-1:0]             busy_cnt;
    logic                         acc_hist;

    logic [TILE_W-1:0]            tiles_clamped;
    logic [TILE_W-1:0]            next_idx;
    logic                         accept;
    logic                         acc_en;
    logic [DIM-1:0][NUM_BIT-1:0]  acc_q;

    always_comb begin
        tiles_clamped = (bus.i_job_tiles > TILE_W'(MAX_TILES))
                        ? TILE_W'(MAX_TILES) : bus.i_job_tiles;
        next_idx      = TILE_W'(idx) + TILE_W'(1);
        accept        = (state == ST_IDLE) && bus.i_job_valid && bus.o_job_ready;
        acc_en        = (state == ST_ACCUM);
    end

    assign bus.o_fetch_tile = idx;
    assign bus.o_y_vector   = acc_q;

    mvm_acc_bank #(
        .NUM_BIT (NUM_BIT),
        .DIM     (DIM)
    ) u_acc_bank (
        .clk    (i_clk_mvmSched),
        .rst    (i_rst_mvmSched),
        .clr    (accept),
        .en     (acc_en),
        .addend (bus.i_mvm_y),
        .acc    (acc_q)
    );

    always_ff @(posedge i_clk_mvmSched) begin
        if (i_rst_mvmSched) begin
            state           <= ST_IDLE;
            tiles           <= '0;
            idx             <= '0;
            busy_cnt        <= '0;
            acc_hist        <= 1'b0;
            bus.o_job_ready <= 1'b1;
            bus.o_fetch_req <= 1'b0;
            bus.o_mvm_start <= 1'b0;
            bus.o_out_valid <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tiles           <= tiles_clamped;
                        idx             <= '0;
                        bus.o_err       <= 1'b0;
                        bus.o_job_ready <= 1'b0;
                        bus.o_busy      <= 1'b1;
                        // An empty job skips straight to presenting the
                        // freshly cleared (all-zero) accumulators.
                        if (tiles_clamped == '0) begin
                            state           <= ST_OUTPUT;
                            bus.o_out_valid <= 1'b1;
                        end else begin
                            state           <= ST_FETCH;
                            bus.o_fetch_req <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (bus.i_fetch_ack) begin
                        state           <= ST_START;
                        bus.o_fetch_req <= 1'b0;
                        bus.o_mvm_start <= 1'b1;
                    end
                end

                ST_START: begin
                    state           <= ST_BUSY;
                    bus.o_mvm_start <= 1'b0;
                    // Forget any isAcc level left over from the previous tile
                    // so only a fresh 1->0 transition counts as completion.
                    acc_hist        <= 1'b0;
                    busy_cnt        <= '0;
                end

                ST_BUSY: begin
                    acc_hist <= bus.i_mvm_isAcc;
                    busy_cnt <= busy_cnt + CNT_W'(1);
                    if (acc_hist && !bus.i_mvm_isAcc) begin
                        state <= ST_ACCUM;
                    end else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state           <= ST_IDLE;
                        bus.o_err       <= 1'b1;
                        bus.o_job_ready <= 1'b1;
                        bus.o_busy      <= 1'b0;
                    end
                end

                ST_ACCUM: begin
                    // Index only advances when another tile follows, so it
                    // never wraps past the last valid tile number.
                    if (next_idx < tiles) begin
                        state           <= ST_FETCH;
                        idx             <= idx + IDX_W'(1);
                        bus.o_fetch_req <= 1'b1;
                    end else begin
                        state           <= ST_OUTPUT;
                        bus.o_out_valid <= 1'b1;
                    end
                end

                ST_OUTPUT: begin
                    if (bus.i_out_ready) begin
                        state           <= ST_IDLE;
                        bus.o_out_valid <= 1'b0;
                        bus.o_job_ready <= 1'b1;
                        bus.o_busy      <= 1'b0;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    bus.o_job_ready <= 1'b1;
                    bus.o_fetch_req <= 1'b0;
                    bus.o_mvm_start <= 1'b0;
                    bus.o_out_valid <= 1'b0;
                    bus.o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_sched.sv
// Directed self-checking bench for mvm_sched. The MVM datapath model raises
// isAcc together with the start pulse and keeps it high mvm_d cycles in total;
// operands are acknowledged in the same cycle they are requested.
module tb_mvm_sched;

    localparam int unsigned NB = 8;
    localparam int unsigned DM = 8;
    localparam int unsigned MT = 16;

    typedef logic [DM-1:0][NB-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hang = 1'b0;
    int   mvm_d = 4;
    int   mvm_cnt = 0;
    int   start_total = 0;
    vec_t y_tab [MT];
    int   n_cmp = 0;
    int   n_bad = 0;

    mvm_sched_if #(.NUM_BIT(NB), .DIM(DM), .MAX_TILES(MT)) bus ();

    mvm_sched #(
        .NUM_BIT   (NB),
        .DIM       (DM),
        .MAX_TILES (MT),
        .TIMEOUT   (1024)
    ) dut (
        .i_clk_mvmSched (clk),
        .i_rst_mvmSched (rst),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.i_fetch_ack = bus.o_fetch_req;
    assign bus.i_mvm_isAcc = hang | bus.o_mvm_start | (mvm_cnt != 0);
    assign bus.i_mvm_y     = y_tab[bus.o_fetch_tile];

    always @(posedge clk) begin
        if (rst) mvm_cnt <= 0;
        else if (bus.o_mvm_start) mvm_cnt <= mvm_d - 1;
        else if (mvm_cnt != 0) mvm_cnt <= mvm_cnt - 1;
    end

    always @(posedge clk) begin
        if (bus.o_mvm_start) start_total <= start_total + 1;
    end

    function automatic vec_t fill(input logic [7:0] b);
        vec_t v;
        for (int i = 0; i < int'(DM); i++) v[i] = b;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job for one edge; returns 1 time unit after the accepting edge.
    task automatic start_job(input int n);
        bus.i_job_valid = 1'b1;
        bus.i_job_tiles = 5'(n);
        tick();
        bus.i_job_valid = 1'b0;
    endtask

    // k = edges after the accepting edge until o_out_valid is seen, so the
    // latency counted from the acceptance cycle is k+1.
    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.o_out_valid && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic finish_job();
        bus.i_out_ready = 1'b1;
        tick();
        bus.i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_job_ready, bus.o_busy, bus.o_fetch_req, bus.o_mvm_start,
             bus.o_out_valid, bus.o_err} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 100000", {bus.o_job_ready,
                     bus.o_busy, bus.o_fetch_req, bus.o_mvm_start, bus.o_out_valid, bus.o_err});
        end
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h00)) begin
            n_bad++;
            $display("FAIL reset_y: got %h want 0", bus.o_y_vector);
        end
    endtask

    task automatic test_single();
        int k;
        int s0;
        y_tab[0] = fill(8'h10);
        mvm_d = 4;
        s0 = start_total;
        start_job(1);
        wait_valid(k);
        n_cmp++;
        if (k + 1 !== 8) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want 8", k + 1);
        end
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h10)) begin
            n_bad++;
            $display("FAIL single_y: got %h want 1010101010101010", bus.o_y_vector);
        end
        n_cmp++;
        if (start_total - s0 !== 1) begin
            n_bad++;
            $display("FAIL single_starts: got %0d want 1", start_total - s0);
        end
        finish_job();
    endtask

    task automatic test_zero_tiles();
        int k;
        int s0;
        s0 = start_total;
        start_job(0);
        wait_valid(k);
        n_cmp++;
        if (k + 1 !== 1) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 1", k + 1);
        end
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h00)) begin
            n_bad++;
            $display("FAIL zero_y: got %h want 0", bus.o_y_vector);
        end
        finish_job();
        n_cmp++;
        if (start_total - s0 !== 0) begin
            n_bad++;
            $display("FAIL zero_starts: got %0d want 0", start_total - s0);
        end
    endtask

    task automatic test_saturation();
        int k;
        mvm_d = 4;
        y_tab[0] = fill(8'h60);
        y_tab[1] = fill(8'h60);
        start_job(2);
        wait_valid(k);
        n_cmp++;
        if (k + 1 !== 15) begin
            n_bad++;
            $display("FAIL sat_pos_latency: got %0d want 15", k + 1);
        end
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h7F)) begin
            n_bad++;
            $display("FAIL sat_pos_y: got %h want 7f7f7f7f7f7f7f7f", bus.o_y_vector);
        end
        finish_job();
        y_tab[0] = fill(8'h80);
        y_tab[1] = fill(8'hC0);
        start_job(2);
        wait_valid(k);
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h80)) begin
            n_bad++;
            $display("FAIL sat_neg_y: got %h want 8080808080808080", bus.o_y_vector);
        end
        finish_job();
    endtask

    // Per-element values differ; elements 6 and 7 saturate after tile 1 and
    // then come back down with tile 2.
    task automatic test_mixed();
        int k;
        mvm_d = 2;
        y_tab[0] = 64'h7060504030201000;
        y_tab[1] = fill(8'h20);
        y_tab[2] = fill(8'hF0);
        start_job(3);
        wait_valid(k);
        n_cmp++;
        if (k + 1 !== 16) begin
            n_bad++;
            $display("FAIL mixed_latency: got %0d want 16", k + 1);
        end
        n_cmp++;
        if (bus.o_y_vector !== 64'h6F6F605040302010) begin
            n_bad++;
            $display("FAIL mixed_y: got %h want 6f6f605040302010", bus.o_y_vector);
        end
        finish_job();
    endtask

    task automatic test_clamp();
        int k;
        int s0;
        mvm_d = 2;
        for (int i = 0; i < int'(MT); i++) y_tab[i] = fill(8'h01);
        s0 = start_total;
        start_job(31);
        wait_valid(k);
        n_cmp++;
        if (k + 1 !== 81) begin
            n_bad++;
            $display("FAIL clamp_latency: got %0d want 81", k + 1);
        end
        n_cmp++;
        if (bus.o_y_vector !== fill(8'h10)) begin
            n_bad++;
            $display("FAIL clamp_y: got %h want 1010101010101010", bus.o_y_vector);
        end
        n_cmp++;
        if (start_total - s0 !== 16) begin
            n_bad++;
            $display("FAIL clamp_starts: got %0d want 16", start_total - s0);
        end
        finish_job();
    endtask

    task automatic test_output_hold();
        int k;
        int bad_hold;
        mvm_d = 2;
        y_tab[0] = fill(8'h33);
        start_job(1);
        wait_valid(k);
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_y_vector !== fill(8'h33) || bus.o_out_valid !== 1'b1 ||
                bus.o_job_ready !== 1'b0) bad_hold++;
        end
        n_cmp++;
        if (bad_hold !== 0) begin
            n_bad++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad_hold);
        end
        // Job offered in the handshake cycle must not be taken.
        bus.i_job_valid = 1'b1;
        bus.i_job_tiles = 5'd1;
        bus.i_out_ready = 1'b1;
        tick();
        bus.i_job_valid = 1'b0;
        bus.i_out_ready = 1'b0;
        n_cmp++;
        if ({bus.o_out_valid, bus.o_job_ready, bus.o_busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL hold_handshake: got %b want 010",
                     {bus.o_out_valid, bus.o_job_ready, bus.o_busy});
        end
    endtask

    task automatic test_timeout();
        int n;
        logic seen_ov;
        hang = 1'b1;
        y_tab[0] = fill(8'h55);
        start_job(1);
        tick();
        tick();
        n = 0;
        seen_ov = 1'b0;
        while (!bus.o_err && n < 1100) begin
            tick();
            n++;
            if (bus.o_out_valid) seen_ov = 1'b1;
        end
        n_cmp++;
        if (n !== 1024) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d want 1024", n);
        end
        n_cmp++;
        if ({bus.o_job_ready, bus.o_busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_idle: got %b want 10", {bus.o_job_ready, bus.o_busy});
        end
        for (int i = n; i < 1100; i++) begin
            tick();
            if (bus.o_out_valid) seen_ov = 1'b1;
        end
        hang = 1'b0;
        n_cmp++;
        if (seen_ov !== 1'b0 || bus.o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_noout: got ov=%b err=%b want ov=0 err=1",
                     seen_ov, bus.o_err);
        end
    endtask

    task automatic test_reset_in_busy();
        int s0;
        logic bad_after;
        mvm_d = 4;
        y_tab[0] = fill(8'h11);
        y_tab[1] = fill(8'h22);
        y_tab[2] = fill(8'h33);
        s0 = start_total;
        start_job(3);
        n_cmp++;
        if (bus.o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_clears_err: got %b want 0", bus.o_err);
        end
        repeat (10) tick();
        n_cmp++;
        if ({bus.o_busy, bus.o_fetch_tile} !== 5'b1_0001 || bus.o_y_vector !== fill(8'h11)) begin
            n_bad++;
            $display("FAIL rb_partial: got busy/tile=%b y=%h want 10001 y=1111111111111111",
                     {bus.o_busy, bus.o_fetch_tile}, bus.o_y_vector);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.o_job_ready, bus.o_busy, bus.o_fetch_req, bus.o_mvm_start,
             bus.o_out_valid, bus.o_err} !== 6'b100000 || bus.o_y_vector !== fill(8'h00)) begin
            n_bad++;
            $display("FAIL rb_reset: got ctrl=%b y=%h want ctrl=100000 y=0", {bus.o_job_ready,
                     bus.o_busy, bus.o_fetch_req, bus.o_mvm_start, bus.o_out_valid, bus.o_err},
                     bus.o_y_vector);
        end
        bad_after = 1'b0;
        repeat (40) begin
            tick();
            if (bus.o_out_valid || bus.o_mvm_start || bus.o_busy) bad_after = 1'b1;
        end
        n_cmp++;
        if (bad_after !== 1'b0 || start_total - s0 !== 2) begin
            n_bad++;
            $display("FAIL rb_aborted: got activity=%b starts=%0d want activity=0 starts=2",
                     bad_after, start_total - s0);
        end
    endtask

    initial begin
        bus.i_job_valid = 1'b0;
        bus.i_job_tiles = '0;
        bus.i_out_ready = 1'b0;
        for (int i = 0; i < int'(MT); i++) y_tab[i] = '0;
        test_reset();
        test_single();
        test_zero_tiles();
        test_saturation();
        test_mixed();
        test_clamp();
        test_output_hold();
        test_timeout();
        test_reset_in_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
